alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts one 16-bit instruction word per handshake, decodes it into
//  the 8-bit ALU opcode, reads operands from the register file, drives the combinational alu, and writes C back.

---
 rtl/alu_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one instruction, reads operands, drives the alu, writes back.
// Define ALU_ISSUE_BYPASS_EN to merge writeback into EXEC (3-cycle issue).
module alu_issue_ctrl #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FLAG_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [15:0]           inst,
    output logic [REG_ADDR_W-1:0] rf_raddr_a,
    output logic [REG_ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]     rf_rdata_a,
    input  logic [DATA_W-1:0]     rf_rdata_b,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_carry_in,
    output logic [7:0]            alu_opcode,
    input  logic [DATA_W-1:0]     alu_c,
    input  logic [FLAG_W-1:0]     alu_flags,
    output logic [FLAG_W-1:0]     psr,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_inst;
    logic [FLAG_W-1:0]   r_psr;
`ifndef ALU_ISSUE_BYPASS_EN
    logic [DATA_W-1:0]   r_c;
    logic [FLAG_W-1:0]   r_flags;
`endif

    logic [3:0]          w_op;
    logic [3:0]          w_ext;
    logic [7:0]          w_imm8;
    logic                w_imm_op;
    logic                w_sext;
    logic [7:0]          w_opcode;
    logic [DATA_W-1:0]   w_b;
    logic                w_legal;
    logic                w_nop;
    logic                w_cmp;
    logic                w_wr;
    logic                w_upd;

    assign w_op     = r_inst[15:12];
    assign w_ext    = r_inst[7:4];
    assign w_imm8   = r_inst[7:0];
    assign w_imm_op = w_op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6,
                                   4'h7, 4'h9, 4'hA, 4'hB, 4'hC};
    assign w_sext   = w_op inside {4'h5, 4'h7, 4'h9, 4'hB};

    always_comb begin
        w_opcode = 8'h00;
        w_b      = '0;
        w_legal  = 1'b0;
        w_nop    = 1'b0;
        w_cmp    = 1'b0;
        unique case (1'b1)
            (w_op == 4'h0): begin
                w_opcode = {4'h0, w_ext};
                w_b      = rf_rdata_b;
                w_nop    = (w_ext == 4'h0);
                w_legal  = w_nop || (w_ext inside {[4'h1:4'h9], 4'hB, 4'hF});
                w_cmp    = (w_ext == 4'hB) || (w_ext == 4'h8);
            end
            (w_op == 4'h8): begin
                w_opcode = {4'h8, w_ext};
                w_b      = r_inst[6] ? rf_rdata_b
                                     : {{(DATA_W-4){1'b0}}, r_inst[3:0]};
                w_legal  = (w_ext <= 4'hB);
            end
            w_imm_op: begin
                w_opcode = {w_op, 4'h0};
                w_b      = w_sext ? {{(DATA_W-8){w_imm8[7]}}, w_imm8}
                                  : {{(DATA_W-8){1'b0}}, w_imm8};
                w_legal  = 1'b1;
                w_cmp    = (w_op == 4'hB) || (w_op == 4'hC);
            end
            default: ;
        endcase
    end

    assign w_wr  = w_legal & ~w_nop & ~w_cmp;
    assign w_upd = w_legal & ~w_nop;

    assign rf_raddr_a   = r_inst[11:8];
    assign rf_raddr_b   = r_inst[3:0];
    assign rf_waddr     = r_inst[11:8];
    assign alu_carry_in = r_psr[3];
    assign psr          = r_psr;
`ifdef ALU_ISSUE_BYPASS_EN
    assign rf_wdata     = alu_c;
`else
    assign rf_wdata     = r_c;
`endif

    // Retire strobes are masked by reset so an aborted instruction never writes.
    always_comb begin
        w_next     = r_state;
        inst_ready = 1'b0;
        rf_we      = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        alu_opcode = 8'h00;
        alu_a      = '0;
        alu_b      = '0;
        unique case (r_state)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) w_next = S_READ;
            end
            S_READ: w_next = S_EXEC;
            S_EXEC: begin
                alu_opcode = w_opcode;
                alu_a      = rf_rdata_a;
                alu_b      = w_b;
`ifdef ALU_ISSUE_BYPASS_EN
                rf_we   = w_wr & ~reset;
                done    = w_legal & ~reset;
                illegal = ~w_legal & ~reset;
                w_next  = S_IDLE;
`else
                w_next  = S_WB;
`endif
            end
            S_WB: begin
`ifndef ALU_ISSUE_BYPASS_EN
                rf_we   = w_wr & ~reset;
                done    = w_legal & ~reset;
                illegal = ~w_legal & ~reset;
`endif
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_inst  <= '0;
            r_psr   <= '0;
`ifndef ALU_ISSUE_BYPASS_EN
            r_c     <= '0;
            r_flags <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && inst_valid) r_inst <= inst;
`ifdef ALU_ISSUE_BYPASS_EN
            if (r_state == S_EXEC && w_upd) r_psr <= alu_flags;
`else
            if (r_state == S_EXEC) begin
                r_c     <= alu_c;
                r_flags <= alu_flags;
            end
            if (r_state == S_WB && w_upd) r_psr <= r_flags;
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset abort,
// and random instructions against a decode-level reference model.
module tb_alu_issue_ctrl;

    localparam int EXC = 2;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int WBC = 2;
`else
    localparam int WBC = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_a, alu_b, alu_c;
    logic        alu_carry_in;
    logic [7:0]  alu_opcode;
    logic [4:0]  alu_flags, psr;
    logic        done, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_opcode(alu_opcode), .alu_c(alu_c), .alu_flags(alu_flags),
        .psr(psr), .done(done), .illegal(illegal)
    );

    // Behavioural alu used by both the environment and the reference model.
    function automatic logic [20:0] alu_f(input logic [7:0] op,
                                          input logic [15:0] a, b,
                                          input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic [4:0]  f;
        s = '0; c = '0; f = '0;
        case (op)
            8'h05, 8'h50, 8'h06, 8'h60: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[15:0]; f[3] = s[16];
                f[2] = (a[15] == b[15]) && (c[15] != a[15]);
            end
            8'h07, 8'h70, 8'h04: begin
                s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
                c = s[15:0]; f[3] = s[16];
                f[2] = (a[15] == b[15]) && (c[15] != a[15]);
            end
            8'h09, 8'h90: begin
                c = a - b; f[3] = (a < b);
                f[2] = (a[15] != b[15]) && (c[15] != a[15]);
            end
            8'h0B, 8'h08, 8'hB0, 8'hC0: begin
                f[4] = (a == b); f[1] = (a < b);
                f[0] = ($signed(a) < $signed(b));
            end
            default: begin
                if (op[7:4] == 4'h8) begin
                    c = op[0] ? (a >> b[3:0]) : (a << b[3:0]);
                end else begin
                    c = a ^ b ^ {op, op};
                    f = c[4:0] ^ op[4:0];
                end
            end
        endcase
        return {f, c};
    endfunction

    always_comb {alu_flags, alu_c} = alu_f(alu_opcode, alu_a, alu_b, alu_carry_in);

    logic [15:0] rf_mem [16];
    logic        bk_we = 1'b0;
    logic [3:0]  bk_addr = '0;
    logic [15:0] bk_data = '0;

    always @(posedge clk) begin
        rf_rdata_a <= rf_mem[rf_raddr_a];
        rf_rdata_b <= rf_mem[rf_raddr_b];
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (bk_we) rf_mem[bk_addr] <= bk_data;
    end

    logic [15:0] ref_regs [16];
    logic [4:0]  ref_psr;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [7:0]  op;
        logic [15:0] b;
        logic [15:0] wd;
        bit          legal;
        bit          we;
        logic [4:0]  psr;
        bit          hold;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] ad, input logic [15:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = ad; bk_data = d;
        @(negedge clk);
        bk_we = 1'b0;
        ref_regs[ad] = d;
    endtask

    task automatic predict(input logic [15:0] ins,
                           output logic [7:0] op8, output logic [15:0] a,
                           output logic [15:0] b, output logic [15:0] wd,
                           output bit legal, output bit we,
                           output logic [4:0] npsr);
        logic [3:0]  op, ext, rs;
        logic [7:0]  imm;
        logic [20:0] r;
        bit          cmp, nop;
        op = ins[15:12]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
        legal = 0; cmp = 0; nop = 0; op8 = 8'h00; b = '0;
        a = ref_regs[ins[11:8]];
        if (op == 4'h0) begin
            op8 = {4'h0, ext}; b = ref_regs[rs]; nop = (ext == 4'h0);
            legal = nop || (ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                        4'h7, 4'h8, 4'h9, 4'hB, 4'hF});
            cmp = (ext == 4'hB) || (ext == 4'h8);
        end else if (op == 4'h8) begin
            op8 = {4'h8, ext};
            b = ext[2] ? ref_regs[rs] : {12'h000, rs};
            legal = (ext <= 4'hB);
        end else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                                4'h9, 4'hA, 4'hB, 4'hC}) begin
            op8 = {op, 4'h0};
            b = (op inside {4'h5, 4'h7, 4'h9, 4'hB}) ? {{8{imm[7]}}, imm}
                                                     : {8'h00, imm};
            legal = 1;
            cmp = (op == 4'hB) || (op == 4'hC);
        end
        r = alu_f(op8, a, b, ref_psr[3]);
        wd = r[15:0];
        we = legal && !nop && !cmp;
        npsr = (legal && !nop) ? r[20:16] : ref_psr;
    endtask

    task automatic run_inst(input logic [15:0] ins, input logic [7:0] e_op,
                            input logic [15:0] e_a, input logic [15:0] e_b,
                            input logic [15:0] e_wd, input bit e_legal,
                            input bit e_we, input logic [4:0] e_psr,
                            input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'h0, inst_ready}, 32'h1);
        inst_valid = 1'b1;
        inst = ins;
        @(posedge clk);
        for (int c = 1; c <= WBC + 1; c++) begin
            @(negedge clk);
            if (c == EXC && e_legal) begin
                chk("alu_opcode", {24'h0, alu_opcode}, {24'h0, e_op});
                chk("alu_a", {16'h0, alu_a}, {16'h0, e_a});
                chk("alu_b", {16'h0, alu_b}, {16'h0, e_b});
                chk("alu_cin", {31'h0, alu_carry_in}, {31'h0, ref_psr[3]});
            end
            chk("rf_we", {31'h0, rf_we}, {31'h0, (c == WBC) && e_we});
            chk("done", {31'h0, done}, {31'h0, (c == WBC) && e_legal});
            chk("illegal", {31'h0, illegal}, {31'h0, (c == WBC) && !e_legal});
            chk("inst_ready", {31'h0, inst_ready}, {31'h0, c == WBC + 1});
            if (c == WBC && e_we) begin
                chk("rf_waddr", {28'h0, rf_waddr}, {28'h0, ins[11:8]});
                chk("rf_wdata", {16'h0, rf_wdata}, {16'h0, e_wd});
            end
            if (c == WBC + 1) chk("psr", {27'h0, psr}, {27'h0, e_psr});
            inst_valid = hold && (c <= WBC);
            inst = ~ins;
        end
        inst_valid = 1'b0;
        if (e_we) ref_regs[ins[11:8]] = e_wd;
        ref_psr = e_psr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  p_op;
        logic [15:0] p_a, p_b, p_wd, rins;
        bit          p_legal, p_we;
        logic [4:0]  p_psr;

        tbl[0] = '{16'h0152, 16'h0005, 16'h0003, 8'h05, 16'h0003, 16'h0008, 1, 1, 5'b00000, 0};
        tbl[1] = '{16'h51FF, 16'h0000, 16'h0003, 8'h50, 16'hFFFF, 16'hFFFF, 1, 1, 5'b00000, 0};
        tbl[2] = '{16'h61FF, 16'h0000, 16'h0003, 8'h60, 16'h00FF, 16'h00FF, 1, 1, 5'b00000, 0};
        tbl[3] = '{16'h8104, 16'h0003, 16'h0003, 8'h80, 16'h0004, 16'h0030, 1, 1, 5'b00000, 0};
        tbl[4] = '{16'h01B2, 16'h0002, 16'h0005, 8'h0B, 16'h0005, 16'h0000, 1, 0, 5'b00011, 1};
        tbl[5] = '{16'hD000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 0, 5'b00011, 1};

        reset = 1'b1;
        inst_valid = 1'b0;
        inst = '0;
        ref_psr = '0;
        for (int i = 0; i < 16; i++) preload(i[3:0], 16'($urandom));
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'h0, inst_ready}, 32'h1);
        chk("rst_psr", {27'h0, psr}, 32'h0);
        chk("rst_we", {31'h0, rf_we}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_illegal", {31'h0, illegal}, 32'h0);
        chk("rst_opcode", {24'h0, alu_opcode}, 32'h0);
        chk("rst_alu_a", {16'h0, alu_a}, 32'h0);
        chk("rst_alu_b", {16'h0, alu_b}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            preload(4'd1, tbl[i].r1);
            preload(4'd2, tbl[i].r2);
            run_inst(tbl[i].ins, tbl[i].op, tbl[i].r1, tbl[i].b, tbl[i].wd,
                     tbl[i].legal, tbl[i].we, tbl[i].psr, tbl[i].hold);
        end

        // Reset while an ADD sits in EXEC: no writeback, psr cleared.
        preload(4'd1, 16'h0005);
        preload(4'd2, 16'h0003);
        @(negedge clk);
        inst_valid = 1'b1;
        inst = 16'h0152;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        chk("abort_opcode", {24'h0, alu_opcode}, 32'h05);
        reset = 1'b1;
        #1;
        chk("abort_we_exec", {31'h0, rf_we}, 32'h0);
        @(negedge clk);
        chk("abort_we", {31'h0, rf_we}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_psr", {27'h0, psr}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'h0, inst_ready}, 32'h1);
        chk("abort_r1", {16'h0, rf_mem[1]}, 32'h0005);
        ref_psr = '0;

        for (int i = 0; i < 150; i++) begin
            rins = 16'($urandom);
            predict(rins, p_op, p_a, p_b, p_wd, p_legal, p_we, p_psr);
            run_inst(rins, p_op, p_a, p_b, p_wd, p_legal, p_we, p_psr,
                     bit'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 16; i++)
            chk("final_reg", {16'h0, rf_mem[i]}, {16'h0, ref_regs[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
